// File: rtl/bcd_pkg.sv
// ============================================================================
// Module      : bcd_pkg
// Description : Shared types and constants for the binary-to-BCD path.
//               The BCD-to-7-segment decoders also use BCD_DIGIT_W.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } bcd_state_e;

    localparam int                     BCD_DIGIT_W   = 4;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [BCD_DIGIT_W-1:0] ADJ_OFFSET    = 4'd3;

endpackage : bcd_pkg

`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
// ============================================================================
// Module      : bcd_digit_adjust
// Description : Double-dabble correction for one digit: add 3 when >= 5.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= ADJ_THRESHOLD) begin
            adjusted = digit + ADJ_OFFSET;
        end
    end

endmodule : bcd_digit_adjust

`default_nettype wire

// File: rtl/binary_to_bcd.sv
// ============================================================================
// Module      : binary_to_bcd
// Description : Sequential shift-and-add-3 binary to packed BCD converter,
//               one input bit per clock, with start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module binary_to_bcd
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [WIDTH-1:0]              binary,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          overflow
);

    localparam int               DIG_W = BCD_DIGIT_W * DIGITS;
    localparam int               SR_W  = DIG_W + WIDTH;
    localparam int               CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_LAST_SHIFT = CNT_W'(WIDTH - 1);

    bcd_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic               ovf_q, ovf_d;
    logic [DIG_W-1:0]   bcd_q, bcd_d;
    logic               ovf_out_q, ovf_out_d;
    logic               done_q, done_d;

    logic [DIG_W-1:0]   w_adj_digits;
    logic [SR_W-1:0]    w_shifted;
    logic               w_shift_out;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adjust u_adj (
                .digit    (sr_q[WIDTH + g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .adjusted (w_adj_digits[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Bit leaving the top digit is only nonzero when the value no longer fits.
    assign w_shifted   = {w_adj_digits[DIG_W-2:0], sr_q[WIDTH-1:0], 1'b0};
    assign w_shift_out = w_adj_digits[DIG_W-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        ovf_d     = ovf_q;
        bcd_d     = bcd_q;
        ovf_out_d = ovf_out_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = {{DIG_W{1'b0}}, binary};
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = w_shifted;
                ovf_d = ovf_q | w_shift_out;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST_SHIFT) begin
                    bcd_d     = w_shifted[SR_W-1 -: DIG_W];
                    ovf_out_d = ovf_q | w_shift_out;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            ovf_q     <= 1'b0;
            bcd_q     <= '0;
            ovf_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            ovf_q     <= ovf_d;
            bcd_q     <= bcd_d;
            ovf_out_q <= ovf_out_d;
            done_q    <= done_d;
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_out_q;

endmodule : binary_to_bcd

`default_nettype wire

// File: tb/tb_binary_to_bcd.sv
// ============================================================================
// Module      : tb_binary_to_bcd
// Description : Bench for binary_to_bcd; 3-digit and 2-digit instances share
//               the same stimulus, results checked against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_binary_to_bcd;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  binary = '0;

    logic        busy3, done3, overflow3;
    logic [11:0] bcd3;
    logic        busy2, done2, overflow2;
    logic [7:0]  bcd2;

    int errors = 0;
    int checks = 0;

    logic [12:0] q3[$];
    logic [12:0] q2[$];
    logic        prev_done3 = 1'b0;
    logic        prev_done2 = 1'b0;

    binary_to_bcd #(.WIDTH(8), .DIGITS(3)) dut3 (
        .clock(clock), .reset(reset), .start(start), .binary(binary),
        .busy(busy3), .done(done3), .bcd(bcd3), .overflow(overflow3)
    );

    binary_to_bcd #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clock(clock), .reset(reset), .start(start), .binary(binary),
        .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {overflow, bcd[11:0]} from decimal arithmetic, digits beyond d left zero
    function automatic logic [12:0] model(input int v, input int d);
        logic [11:0] b;
        int lim;
        int r;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        r = v % lim;
        b = '0;
        for (int i = 0; i < d; i++) begin
            b[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return {(v >= lim), b};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input int v);
        q3.push_back(model(v, 3));
        q2.push_back(model(v, 2));
    endtask

    // Waits for done starting one cycle after the accept edge; checks latency.
    task automatic wait_done(input string tag);
        int n;
        int busy_cnt;
        n = 0;
        busy_cnt = 0;
        while (done3 !== 1'b1 && n < 20) begin
            if (busy3 === 1'b1 && busy2 === 1'b1) busy_cnt++;
            tick();
            n++;
        end
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_busy_cycles"}, busy_cnt, 8);
        chk({tag, "_busy_at_done"}, {busy3, busy2}, 2'b00);
    endtask

    task automatic convert(input int v, input string tag);
        start = 1'b1;
        binary = 8'(v);
        push(v);
        tick();
        start = 1'b0;
        binary = 8'hA5;
        wait_done(tag);
        tick();
    endtask

    always @(negedge clock) begin
        if (done3 === 1'b1) begin
            chk("done3_expected", q3.size() != 0, 1);
            if (q3.size() != 0) begin
                logic [12:0] e;
                e = q3.pop_front();
                chk("bcd3_result", {overflow3, bcd3}, e);
            end
        end
        if (done2 === 1'b1) begin
            chk("done2_expected", q2.size() != 0, 1);
            if (q2.size() != 0) begin
                logic [12:0] e;
                e = q2.pop_front();
                chk("bcd2_result", {overflow2, bcd2}, {e[12], e[7:0]});
            end
        end
        if (prev_done3) chk("done3_one_cycle", done3, 1'b0);
        if (prev_done2) chk("done2_one_cycle", done2, 1'b0);
        prev_done3 = done3;
        prev_done2 = done2;
    end

    initial begin
        reset = 1'b1;
        tick();
        tick();
        chk("reset_state3", {busy3, done3, overflow3, bcd3}, 15'h0);
        chk("reset_state2", {busy2, done2, overflow2, bcd2}, 11'h0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_state3", {busy3, done3, overflow3, bcd3}, 15'h0);
        end

        convert(255, "c255");
        convert(0,   "c0");
        convert(99,  "c99");
        convert(100, "c100");

        // start during SHIFT is ignored
        start = 1'b1;
        binary = 8'd42;
        push(42);
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        binary = 8'd200;
        tick();
        start = 1'b0;
        binary = 8'd7;
        begin
            int n;
            n = 3;
            while (done3 !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk("ignored_start_latency", n, 8);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("no_extra_done", {done3, busy3}, 2'b00);
            tick();
        end

        // Reset mid-conversion: no done, held result cleared
        convert(123, "c123");
        chk("held_bcd3", bcd3, 12'h123);
        chk("held_bcd2", {overflow2, bcd2}, 9'h123);
        start = 1'b1;
        binary = 8'd77;
        push(77);
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        q3.delete();
        q2.delete();
        tick();
        reset = 1'b0;
        chk("abort_state3", {busy3, done3, overflow3, bcd3}, 15'h0);
        chk("abort_state2", {busy2, done2, overflow2, bcd2}, 11'h0);
        for (int i = 0; i < 12; i++) tick();
        chk("abort_no_done", {done3, busy3}, 2'b00);
        convert(77, "c77");

        // Reset and start together: reset wins
        reset = 1'b1;
        start = 1'b1;
        binary = 8'd55;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("reset_beats_start", {busy3, busy2}, 2'b00);
        tick();
        chk("reset_beats_start_idle", busy3, 1'b0);

        // Back-to-back: start held, accepted on each done cycle
        start = 1'b1;
        binary = 8'd10;
        push(10);
        tick();
        binary = 8'd11;
        wait_done("b2b10");
        push(11);
        tick();
        binary = 8'd12;
        chk("b2b_accept11", busy3, 1'b1);
        wait_done("b2b11");
        push(12);
        tick();
        start = 1'b0;
        chk("b2b_accept12", busy3, 1'b1);
        wait_done("b2b12");
        tick();

        for (int i = 0; i < 4; i++) tick();
        chk("queue3_drained", q3.size(), 0);
        chk("queue2_drained", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_binary_to_bcd

`default_nettype wire

// File: doc/binary_to_bcd.md
# binary_to_bcd

Sequential double-dabble (shift-and-add-3) converter that turns an unsigned binary value into packed BCD digits, one bit per clock. It sits directly upstream of the per-digit BCD-to-7-segment decoders: each 4-bit digit slice of its `bcd` output drives one decoder instance. A start/busy/done handshake lets a counter or register file request a conversion and know exactly when the digits are stable.

## Interface
- `WIDTH`, default 8: bit width of the binary input (≥ 1).
- `DIGITS`, default 3: number of BCD digits produced (≥ 1).

- `clock`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request a conversion; sampled only when idle.
- `binary`  in  WIDTH: unsigned value; captured on the accepting edge only.
- `busy`  out  1: high while a conversion is in progress.
- `done`  out  1: one-cycle pulse; `bcd`/`overflow` are valid from this cycle on.
- `bcd`  out  4*DIGITS: packed result; `bcd[3:0]` is the ones digit and `bcd[4*DIGITS-1:4*DIGITS-4]` is the most significant digit.
- `overflow`  out  1: high if the value exceeds 10^DIGITS − 1. The `bcd` output is then the value modulo 10^DIGITS.

## Operation
- FSM states: IDLE, SHIFT.
- IDLE:
  - On `start`=1, load `binary` into the shift register.
  - Clear the working digit register and the working overflow flag.
  - Set bit counter = 0 and go to SHIFT.
- SHIFT, each edge:
  - For every working digit ≥ 5, add 3 (4-bit, no carry out).
  - Then shift {digits, binary} left by one.
  - OR the bit shifted out of the top digit's MSB into the working overflow flag.
  - Increment the counter.
- On the edge that completes shift number WIDTH:
  - Copy the working digits to `bcd` and the working flag to `overflow`.
  - Pulse `done`=1 and return to IDLE.
- `start` while in SHIFT is ignored (no queueing), and `binary` changes during SHIFT have no effect.
- `bcd`/`overflow` hold their last result until the next completion edge. They are never exposed mid-conversion.
- Counter width is $clog2(WIDTH+1). The counter compares against WIDTH−1 at the final shift.
- Digit arithmetic is 4-bit unsigned. After each adjust-and-shift every digit stays in 0–9.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `bcd`=0 (all digits zero), `overflow`=0, counter 0.
- Let E0 be the edge that samples `start`=1 in IDLE:
  - `busy` is high from after E0 through the cycle before E(WIDTH).
  - After E(WIDTH), `busy`=0, `done`=1 for exactly one cycle, and the new `bcd` is visible.
  - Latency is therefore WIDTH clocks from accept to result.
- Back-to-back: `start` held high during the `done` cycle is accepted at E(WIDTH+1). Peak throughput is one conversion per WIDTH+1 clocks.
- `done` is 0 in every cycle except the completion cycle.
- Reset asserted mid-conversion:
  - Aborts on that edge; there is no `done` pulse.
  - All outputs return to reset values, including a previously held `bcd`.
- Reset and `start` high together: reset wins and `start` is dropped.
- WIDTH=1: a single SHIFT edge, so `done` appears one clock after accept.

## Structure
- Shared package `bcd_pkg`:
  - State enum {IDLE, SHIFT}.
  - Constants BCD_DIGIT_W = 4, ADJ_THRESHOLD = 5, ADJ_OFFSET = 3.
  - The 7-segment decoder also uses BCD_DIGIT_W.
- Sub-module `bcd_digit_adjust`: combinational, one 4-bit digit in, returns digit+3 if ≥ 5 else digit. Instantiate it DIGITS times with a generate loop.
- Top level holds the FSM, counter, working shift register (4*DIGITS + WIDTH bits), overflow accumulator and output registers.

## Test plan
- Reset release, no start, 20 cycles → `busy`=0, `done`=0, `bcd`=0x000, `overflow`=0 throughout.
- WIDTH=8, DIGITS=3, `binary`=255 with a one-cycle `start` → `busy` high 8 cycles, `done` pulse after the 8th edge, `bcd`=0x255, `overflow`=0. Repeat with 0 → 0x000, 99 → 0x099, 100 → 0x100.
- `start` and `binary`=42 accepted; at cycle 3 drive `start`=1 with `binary`=200 → ignored; result 0x042 with a single `done` pulse.
- WIDTH=8, DIGITS=2, `binary`=255 → `bcd`=0x55, `overflow`=1. Then convert 99 → 0x99, `overflow`=0.
- Convert 123, then assert `reset` at cycle 4 of a second conversion of 77 → no `done`, `bcd` returns to 0x000. A following conversion of 77 yields 0x077.
- `start` held continuously with `binary` stepping 10, 11, 12 at each accept → `done` every 9 clocks with `bcd` 0x010, 0x011, 0x012.
